compat_40mhz_source: RTL and testbench



---
 rtl/compat_40mhz_source_pkg.sv | 15 +
 rtl/compat_40mhz_source_filt121.sv | 55 +++++
 rtl/compat_40mhz_source.sv | 87 ++++++++
 tb/tb_compat_40mhz_source.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/compat_40mhz_source_pkg.sv
// Shared constants for the 40 MHz compatibility sample source.
package compat_40mhz_source_pkg;

  // Default raw/filtered sample width (12-bit PMT ADCs).
  localparam int unsigned ADC_WIDTH_DEF = 12;

  // ENABLE40 runs 0,1,2; the last phase is the one whose closing edge updates outputs.
  localparam logic [1:0] PHASE_FIRST = 2'd0;
  localparam logic [1:0] PHASE_LAST  = 2'd2;

  // History fill counter saturates here; at this value all three taps hold real samples.
  localparam logic [1:0] FILL_EMPTY = 2'd0;
  localparam logic [1:0] FILL_FULL  = 2'd3;

endpackage

// File: rtl/compat_40mhz_source_filt121.sv
// One PMT channel: 3-tap history, 1-2-1 rounded sum, full-scale detect, held output.
module filt121_chan
  import compat_40mhz_source_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 upd,
  input  logic [ADC_WIDTH-1:0] adc,
  output logic [ADC_WIDTH-1:0] filt,
  output logic                 sat
);

  localparam logic [ADC_WIDTH+1:0] ROUND = (ADC_WIDTH+2)'(2);

  logic [ADC_WIDTH-1:0] r0;
  logic [ADC_WIDTH-1:0] r1;
  logic [ADC_WIDTH-1:0] r2;
  logic [ADC_WIDTH+1:0] sum;
  logic [ADC_WIDTH-1:0] rounded;
  logic                 full;

  // History shift register, runs every edge regardless of phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      r0 <= adc;
      r1 <= r0;
      r2 <= r1;
    end
  end

  // 1-2-1 weighted sum with +2 for round-half-up; max 4*(2^W-1)+2 fits in W+2 bits.
  always_comb begin
    sum     = {2'b00, r2} + {1'b0, r1, 1'b0} + {2'b00, r0} + ROUND;
    rounded = ADC_WIDTH'(sum >> 2);
    full    = (r0 == '1) || (r1 == '1) || (r2 == '1);
  end

  // Output hold register, loads only on the update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      sat  <= 1'b0;
    end else if (upd) begin
      filt <= rounded;
      sat  <= full;
    end
  end

endmodule

// File: rtl/compat_40mhz_source.sv
// 40 MHz compatibility sample source: ENABLE40 phase, fill/VALID tracking, three filter channels.
module compat_40mhz_source
  import compat_40mhz_source_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic                 CLK120,
  input  logic                 RESET_N,
  input  logic                 SYNC,
  input  logic [ADC_WIDTH-1:0] ADC0,
  input  logic [ADC_WIDTH-1:0] ADC1,
  input  logic [ADC_WIDTH-1:0] ADC2,
  output logic [1:0]           ENABLE40,
  output logic [ADC_WIDTH-1:0] ADC40_0,
  output logic [ADC_WIDTH-1:0] ADC40_1,
  output logic [ADC_WIDTH-1:0] ADC40_2,
  output logic                 VALID,
  output logic [2:0]           SAT
);

  logic [1:0] fill;
  logic       upd;

  // Update strobe: closing edge of phase 2, suppressed when SYNC realigns.
  always_comb begin
    upd = (ENABLE40 == PHASE_LAST) && !SYNC;
  end

  // Phase counter 0,1,2,0...; SYNC forces phase 0.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      ENABLE40 <= PHASE_FIRST;
    end else if (SYNC || (ENABLE40 == PHASE_LAST)) begin
      ENABLE40 <= PHASE_FIRST;
    end else begin
      ENABLE40 <= ENABLE40 + 2'd1;
    end
  end

  // History fill counter, saturating; SYNC restarts it since the window is re-qualified.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      fill <= FILL_EMPTY;
    end else if (SYNC) begin
      fill <= FILL_EMPTY;
    end else if (fill != FILL_FULL) begin
      fill <= fill + 2'd1;
    end
  end

  // VALID is re-evaluated only on updates, so SYNC itself leaves it untouched.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      VALID <= 1'b0;
    end else if (upd) begin
      VALID <= (fill == FILL_FULL);
    end
  end

  filt121_chan #(.ADC_WIDTH(ADC_WIDTH)) u_chan0 (
    .clk   (CLK120),
    .rst_n (RESET_N),
    .upd   (upd),
    .adc   (ADC0),
    .filt  (ADC40_0),
    .sat   (SAT[0])
  );

  filt121_chan #(.ADC_WIDTH(ADC_WIDTH)) u_chan1 (
    .clk   (CLK120),
    .rst_n (RESET_N),
    .upd   (upd),
    .adc   (ADC1),
    .filt  (ADC40_1),
    .sat   (SAT[1])
  );

  filt121_chan #(.ADC_WIDTH(ADC_WIDTH)) u_chan2 (
    .clk   (CLK120),
    .rst_n (RESET_N),
    .upd   (upd),
    .adc   (ADC2),
    .filt  (ADC40_2),
    .sat   (SAT[2])
  );

endmodule

// File: tb/tb_compat_40mhz_source.sv
// Self-checking bench for compat_40mhz_source: vector table, corner sequences, random vs model.
module tb_compat_40mhz_source;

  localparam int unsigned W  = 12;
  localparam int          FS = 4095;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         sync  = 1'b0;
  logic [W-1:0] adc0  = '0;
  logic [W-1:0] adc1  = '0;
  logic [W-1:0] adc2  = '0;
  logic [1:0]   enable40;
  logic [W-1:0] o0;
  logic [W-1:0] o1;
  logic [W-1:0] o2;
  logic         valid;
  logic [2:0]   sat;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: last three samples per channel (index 0 newest), edges since realign.
  int hist [3][3];
  int m_out [3];
  int m_sat [3];
  int m_valid;
  int since;

  compat_40mhz_source #(.ADC_WIDTH(W)) dut (
    .CLK120   (clk),
    .RESET_N  (rst_n),
    .SYNC     (sync),
    .ADC0     (adc0),
    .ADC1     (adc1),
    .ADC2     (adc2),
    .ENABLE40 (enable40),
    .ADC40_0  (o0),
    .ADC40_1  (o1),
    .ADC40_2  (o2),
    .VALID    (valid),
    .SAT      (sat)
  );

  always #4 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 3; k++) hist[n][k] = 0;
      m_out[n] = 0;
      m_sat[n] = 0;
    end
    m_valid = 0;
    since   = 0;
  endtask

  // One CLK120 edge of the model, using pre-edge state.
  task automatic model_edge(input bit s, input int a0, input int a1, input int a2);
    int a [3];
    int pre_fill;
    a = '{a0, a1, a2};
    pre_fill = (since < 3) ? since : 3;
    if ((since % 3 == 2) && !s) begin
      for (int n = 0; n < 3; n++) begin
        m_out[n] = (hist[n][2] + 2 * hist[n][1] + hist[n][0] + 2) / 4;
        m_sat[n] = (hist[n][0] == FS || hist[n][1] == FS || hist[n][2] == FS) ? 1 : 0;
      end
      m_valid = (pre_fill == 3) ? 1 : 0;
    end
    for (int n = 0; n < 3; n++) begin
      hist[n][2] = hist[n][1];
      hist[n][1] = hist[n][0];
      hist[n][0] = a[n];
    end
    since = s ? 0 : since + 1;
  endtask

  task automatic compare_all();
    check("enable40", enable40, since % 3);
    check("adc40_0", o0, m_out[0]);
    check("adc40_1", o1, m_out[1]);
    check("adc40_2", o2, m_out[2]);
    check("valid", valid, m_valid);
    check("sat", sat, m_sat[2] * 4 + m_sat[1] * 2 + m_sat[0]);
  endtask

  // Drive inputs (called at negedge), advance one edge, check all outputs #1 later.
  task automatic tick(input bit s, input int a0, input int a1, input int a2);
    sync = s;
    adc0 = a0[W-1:0];
    adc1 = a1[W-1:0];
    adc2 = a2[W-1:0];
    @(posedge clk);
    model_edge(s, a0, a1, a2);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, held over one edge, released at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_async_enable40", enable40, 0);
    check("reset_async_adc40_0", o0, 0);
    check("reset_async_valid", valid, 0);
    check("reset_async_sat", sat, 0);
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] mask;
    int         r2;
    int         r1;
    int         r0;
    int         exp_out;
    logic       exp_sat;
  } vec_t;

  vec_t vecs [7];
  int   held;

  initial begin
    vecs[0] = '{3'b111, 1, 0, 1, 1, 1'b0};
    vecs[1] = '{3'b111, 1, 0, 0, 0, 1'b0};
    vecs[2] = '{3'b111, 0, 1, 0, 1, 1'b0};
    vecs[3] = '{3'b111, 3, 3, 3, 3, 1'b0};
    vecs[4] = '{3'b111, 2, 1, 0, 1, 1'b0};
    vecs[5] = '{3'b111, FS, FS, FS, FS, 1'b1};
    vecs[6] = '{3'b100, 0, 0, FS, 1024, 1'b1};

    model_reset();
    @(negedge clk);
    do_reset();

    // Reset release, constant 100. First update still sees the reset-cleared R2: (0+200+100+2)>>2 = 75.
    for (int k = 1; k <= 8; k++) begin
      tick(0, 100, 100, 100);
      check($sformatf("const_phase_e%0d", k), enable40, k % 3);
      if (k == 3) begin
        check("const_e3_adc40_0", o0, 75);
        check("const_e3_valid", valid, 0);
      end
      if (k == 6) begin
        check("const_e6_adc40_1", o1, 100);
        check("const_e6_valid", valid, 1);
        check("const_e6_sat", sat, 0);
      end
    end

    // Window vectors: SYNC edge loads R2's sample, update lands three edges later.
    for (int i = 0; i < 7; i++) begin
      int v [3];
      tick(1, vecs[i].mask[0] ? vecs[i].r2 : 0, vecs[i].mask[1] ? vecs[i].r2 : 0, vecs[i].mask[2] ? vecs[i].r2 : 0);
      tick(0, vecs[i].mask[0] ? vecs[i].r1 : 0, vecs[i].mask[1] ? vecs[i].r1 : 0, vecs[i].mask[2] ? vecs[i].r1 : 0);
      tick(0, vecs[i].mask[0] ? vecs[i].r0 : 0, vecs[i].mask[1] ? vecs[i].r0 : 0, vecs[i].mask[2] ? vecs[i].r0 : 0);
      tick(0, 0, 0, 0);
      for (int n = 0; n < 3; n++) v[n] = vecs[i].mask[n] ? vecs[i].exp_out : 0;
      check($sformatf("vec%0d_adc40_0", i), o0, v[0]);
      check($sformatf("vec%0d_adc40_1", i), o1, v[1]);
      check($sformatf("vec%0d_adc40_2", i), o2, v[2]);
      check($sformatf("vec%0d_sat", i), sat, vecs[i].exp_sat ? vecs[i].mask : 3'b000);
    end
    // Full-scale sample has left the window by the next update.
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("sat_cleared", sat, 0);
    check("sat_cleared_adc40_2", o2, 0);

    // Impulse of 400 at R2, R1, R0 positions of the update window.
    for (int o = 0; o < 3; o++) begin
      int s [3];
      s = '{0, 0, 0};
      s[o] = 400;
      tick(1, s[0], 0, 0);
      tick(0, s[1], 0, 0);
      tick(0, s[2], 0, 0);
      tick(0, 0, 0, 0);
      check($sformatf("impulse%0d_adc40_0", o), o0, (o == 1) ? 200 : 100);
      check($sformatf("impulse%0d_adc40_1", o), o1, 0);
      check($sformatf("impulse%0d_adc40_2", o), o2, 0);
    end

    // SYNC while ENABLE40 == 1.
    for (int k = 0; k < 7; k++) tick(0, 500, 500, 500);
    while (since % 3 != 1) tick(0, 500, 500, 500);
    check("sync1_pre_valid", valid, 1);
    tick(1, 900, 900, 900);
    check("sync1_enable40", enable40, 0);
    check("sync1_held", o0, 500);
    for (int k = 1; k <= 6; k++) begin
      tick(0, 900, 900, 900);
      if (k == 3) check("sync1_e3_valid", valid, 0);
      if (k == 6) check("sync1_e6_valid", valid, 1);
    end

    // SYNC while ENABLE40 == 2: window differs from held output, yet nothing updates.
    for (int k = 0; k < 7; k++) tick(0, 500, 500, 500);
    while (since % 3 != 0) tick(0, 500, 500, 500);
    tick(0, 900, 900, 900);
    tick(0, 900, 900, 900);
    held = m_out[0];
    check("sync2_pre_held", o0, 500);
    tick(1, 900, 900, 900);
    check("sync2_enable40", enable40, 0);
    check("sync2_no_update", o0, held);
    check("sync2_valid_kept", valid, 1);
    for (int k = 1; k <= 6; k++) begin
      tick(0, 900, 900, 900);
      if (k == 3) check("sync2_e3_valid", valid, 0);
      if (k == 6) check("sync2_e6_valid", valid, 1);
    end

    // Mid-operation reset while VALID and outputs are non-zero, then the release sequence again.
    for (int k = 0; k < 7; k++) tick(0, 1234, 1234, 1234);
    check("midrst_pre_valid", valid, 1);
    check("midrst_pre_adc40_2", o2, 1234);
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick(0, 100, 100, 100);
      if (k == 3) check("midrst_e3_valid", valid, 0);
      if (k == 6) check("midrst_e6_valid", valid, 1);
    end

    // Randomized inputs with occasional SYNC and full-scale/zero samples.
    for (int k = 0; k < 400; k++) begin
      int a [3];
      for (int n = 0; n < 3; n++) begin
        int r;
        r = $urandom_range(0, 7);
        a[n] = (r == 0) ? FS : (r == 1) ? 0 : $urandom_range(0, FS);
      end
      tick($urandom_range(0, 15) == 0, a[0], a[1], a[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
